rc4_keystream_gen: RTL and testbench
====================================

Name: rc4_keystream_gen

Overview:
- Parametrised RC4 engine: variable-length key (1..MAX_KEY_BYTES bytes), internal 256x8 S-box, full KSA then PRGA.
- Delivers keystream bytes over a valid/ready handshake, with byte count, abort and key-length error detection.
- Sits between the key-load logic and the stream XOR datapath; replaces the fixed 32-bit-key engine.

Parameters:
- MAX_KEY_BYTES, 16, maximum key length in bytes; key port width is 8*MAX_KEY_BYTES.
- DROP_N, 256, keystream bytes discarded after KSA when RC4_DROP_EN is defined; range 0..65535.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- key  in  8*MAX_KEY_BYTES  key byte n = key[8n+7:8n]; sampled when start is accepted.
- key_len  in  8  key length in bytes; sampled with start.
- ks_count  in  16  bytes to emit; 0 = unbounded until abort. Sampled with start.
- abort  in  1  terminate any active operation.
- ks_data  out  8  keystream byte.
- ks_valid  out  1  ks_data valid.
- ks_ready  in  1  consumer accepts ks_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when ks_count bytes have been transferred.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: state=IDLE; i=j=0; ks_data=0; ks_valid=busy=done=err=0; remaining-byte counter=0. S-box contents are don't-care.
- Reset mid-operation: returns to IDLE on the next edge; any held ks_valid is dropped.
- Start, legal (start=1 in IDLE, 1<=key_len<=MAX_KEY_BYTES): latch key, key_len and ks_count; go to INIT.
- Start, illegal (key_len=0 or key_len>MAX_KEY_BYTES): pulse err for 1 cycle; stay in IDLE; busy stays 0.
- INIT: 256 cycles, S[i]=i for i=0..255, one write per cycle.
- KSA: 2 cycles per i, for i=0..255.
  - KSA_A: j <= j + S[i] + key[i mod key_len]; all arithmetic mod 256.
  - KSA_B: swap S[i] and S[j]. i==j is a legal no-op swap.
- After KSA: i=j=0.
- PRGA: 2 cycles per byte.
  - PRGA_A: i <= i+1; j <= j+S[i+1].
  - PRGA_B: swap S[i] and S[j]; ks_data <= S[(S[i]+S[j]) mod 256] using pre-swap values, so S[i]+S[j] is the same sum; go to OUT.
- OUT: ks_valid=1; ks_data stays stable while ks_ready=0.
  - On ks_valid&&ks_ready: decrement remaining count when ks_count!=0.
  - Count reaches 0 (ks_count!=0): pulse done, return to IDLE.
  - Otherwise: go to PRGA_A; ks_valid drops during PRGA_A/B.
  - Peak rate: 1 byte per 3 cycles.
- Timing from the start edge (cycle 0, no drop): INIT occupies cycles 1-256; KSA 257-768; PRGA 769-770; first ks_valid in cycle 771.
- abort: highest priority after rst, effective in any non-IDLE state. Next state IDLE; ks_valid=0; no done pulse.
- abort and start in the same cycle in IDLE: abort wins; start is ignored.
- start while busy: ignored.
- i, j wrap mod 256 freely during PRGA; the count is the only termination condition.

Optional Feature:
- Macro RC4_DROP_EN.
- Defined: after KSA, DROP_N PRGA iterations run (2 cycles each) without asserting ks_valid and without decrementing the count. First ks_valid moves to cycle 771+2*DROP_N.
- Undefined: no drop. DROP_N is ignored. The drop counter is not synthesised.

Test Plan:
- key=0x79654B, key_len=3, ks_count=10, ks_ready=1 -> ks_data EB 9F 77 81 B7 34 CA 72 A7 19; first ks_valid at cycle 771; done pulses after the 10th byte.
- key="Wiki" (0x696B6957), key_len=4, ks_count=6, ks_ready toggling 1/0 each cycle -> 60 44 DB 6D 41 B7; ks_data held stable while ks_ready=0.
- key="Secret" (0x746572636553), key_len=6, ks_count=0 -> 04 D4 6B 05 3C A8 7B 59 ...; abort after the 8th byte -> IDLE next cycle, no done, busy=0.
- key_len=0, then key_len=MAX_KEY_BYTES+1 with start -> err pulse each time; busy stays 0; no ks_valid.
- rst asserted mid-KSA, then a legal restart with key "Key" -> identical keystream as the first scenario; start while busy is ignored.
- RC4_DROP_EN defined, DROP_N=2, key "Key", ks_count=3 -> 77 81 B7; first ks_valid at cycle 775.

Source files
------------

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream engine: S-box init, KSA, then PRGA bytes over a valid/ready port.
// Build option RC4_DROP_EN discards the first DROP_N keystream bytes after KSA.
module rc4_keystream_gen #(
  parameter int MAX_KEY_BYTES = 16,
  parameter int DROP_N        = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [8*MAX_KEY_BYTES-1:0] key,
  input  logic [7:0]                 key_len,
  input  logic [15:0]                ks_count,
  input  logic                       abort,
  output logic [7:0]                 ks_data,
  output logic                       ks_valid,
  input  logic                       ks_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  typedef enum logic [2:0] {IDLE, INIT, KSA_A, KSA_B, PRGA_A, PRGA_B, OUT} state_t;

  state_t                     r_state;
  logic [7:0]                 r_s [256];
  logic [7:0]                 r_i, r_j, r_kidx, r_klen;
  logic [8*MAX_KEY_BYTES-1:0] r_key;
  logic [15:0]                r_remain;
  logic                       r_unbounded;
  logic [7:0]                 r_ks_data;
  logic                       r_ks_valid, r_busy, r_done, r_err;
`ifdef RC4_DROP_EN
  logic [15:0]                r_drop;
`endif

  logic [7:0] w_i1, w_si, w_sj, w_si1, w_t, w_kb, w_out;
  logic       w_key_ok;

  assign w_i1     = r_i + 8'd1;
  assign w_si     = r_s[r_i];
  assign w_sj     = r_s[r_j];
  assign w_si1    = r_s[w_i1];
  assign w_t      = w_si + w_sj;
  assign w_kb     = r_key[{r_kidx, 3'b000} +: 8];
  assign w_key_ok = (key_len != 8'd0) && ({1'b0, key_len} <= 9'(MAX_KEY_BYTES));
  // Output byte is read from the post-swap S-box, so bypass the two entries being swapped.
  assign w_out    = (w_t == r_i) ? w_sj : (w_t == r_j) ? w_si : r_s[w_t];

  assign ks_data  = r_ks_data;
  assign ks_valid = r_ks_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_s[r_i] <= r_i;
    end else if (r_state == KSA_B || r_state == PRGA_B) begin
      r_s[r_i] <= w_sj;
      r_s[r_j] <= w_si;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_kidx      <= 8'd0;
      r_klen      <= 8'd0;
      r_key       <= '0;
      r_remain    <= 16'd0;
      r_unbounded <= 1'b0;
      r_ks_data   <= 8'd0;
      r_ks_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef RC4_DROP_EN
      r_drop      <= 16'd0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        if (r_state != IDLE) begin
          r_state    <= IDLE;
          r_ks_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      end else begin
        case (r_state)
          IDLE: if (start) begin
            if (w_key_ok) begin
              r_key       <= key;
              r_klen      <= key_len;
              r_remain    <= ks_count;
              r_unbounded <= (ks_count == 16'd0);
              r_i         <= 8'd0;
              r_j         <= 8'd0;
              r_kidx      <= 8'd0;
              r_busy      <= 1'b1;
              r_state     <= INIT;
`ifdef RC4_DROP_EN
              r_drop      <= 16'(DROP_N);
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          INIT: begin
            r_i <= w_i1;
            if (r_i == 8'hFF) r_state <= KSA_A;
          end
          KSA_A: begin
            r_j     <= r_j + w_si + w_kb;
            r_kidx  <= (r_kidx == r_klen - 8'd1) ? 8'd0 : r_kidx + 8'd1;
            r_state <= KSA_B;
          end
          KSA_B: begin
            r_i <= w_i1;
            if (r_i == 8'hFF) begin
              r_j     <= 8'd0;
              r_state <= PRGA_A;
            end else begin
              r_state <= KSA_A;
            end
          end
          PRGA_A: begin
            r_i     <= w_i1;
            r_j     <= r_j + w_si1;
            r_state <= PRGA_B;
          end
          PRGA_B: begin
            r_ks_data <= w_out;
`ifdef RC4_DROP_EN
            if (r_drop != 16'd0) begin
              r_drop  <= r_drop - 16'd1;
              r_state <= PRGA_A;
            end else
`endif
            begin
              r_ks_valid <= 1'b1;
              r_state    <= OUT;
            end
          end
          OUT: if (ks_ready) begin
            r_ks_valid <= 1'b0;
            if (!r_unbounded && r_remain == 16'd1) begin
              r_remain <= 16'd0;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= IDLE;
            end else begin
              if (!r_unbounded) r_remain <= r_remain - 16'd1;
              r_state <= PRGA_A;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Scoreboard bench for rc4_keystream_gen: array-based RC4 reference model plus known-answer bytes.
`timescale 1ns/1ps
module tb_rc4_keystream_gen;
  localparam int MKB    = 16;
  localparam int DROP_N = 256;
`ifdef RC4_DROP_EN
  localparam int DROP_EFF = DROP_N;
`else
  localparam int DROP_EFF = 0;
`endif
  localparam int LAT = 771 + 2 * DROP_EFF;

  logic             clk, rst, start, abort, ks_ready;
  logic [8*MKB-1:0] key;
  logic [7:0]       key_len;
  logic [15:0]      ks_count;
  logic [7:0]       ks_data;
  logic             ks_valid, busy, done, err;

  rc4_keystream_gen #(.MAX_KEY_BYTES(MKB), .DROP_N(DROP_N)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .key_len(key_len),
    .ks_count(ks_count), .abort(abort), .ks_data(ks_data), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  int n_bytes = 0, n_done = 0, n_err = 0;
  int exp_lat = -1, t_start = 0;
  int rdy_mode = 0;
  logic held = 1'b0;
  logic [7:0] held_data = 8'd0;
  logic [7:0] kat_key [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] kat_sec [8]  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

  localparam logic [8*MKB-1:0] K_KEY    = 128'h79654B;
  localparam logic [8*MKB-1:0] K_WIKI   = 128'h696B6957;
  localparam logic [8*MKB-1:0] K_SECRET = 128'h746572636553;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Straightforward RC4 over an int array; pushes n bytes after skipping DROP_EFF.
  task automatic model_push(input logic [8*MKB-1:0] k, input int len, input int n);
    int s[256];
    int i, j, t;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + s[a] + int'(k[8*(a % len) +: 8])) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int b = 0; b < DROP_EFF + n; b++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (b >= DROP_EFF) exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endtask

  task automatic push_kat_key();
`ifdef RC4_DROP_EN
    model_push(K_KEY, 3, 10);
`else
    foreach (kat_key[n]) exp_q.push_back(kat_key[n]);
`endif
  endtask

  task automatic go(input logic [8*MKB-1:0] k, input int len, input int cnt, input bit arm);
    @(posedge clk); #1;
    key = k; key_len = 8'(len); ks_count = 16'(cnt); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_start = cyc;
    if (arm) exp_lat = LAT;
  endtask

  task automatic wait_done(input int done0);
    int c = 0;
    while (n_done == done0 && c < 4000 + 2 * DROP_EFF) begin
      @(negedge clk); c++;
    end
    chk("done_pulses", n_done - done0, 1);
    chk("queue_empty_at_done", exp_q.size(), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("valid_after_done", int'(ks_valid), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (held) chk("hold_stable", int'({ks_valid, ks_data}), int'({1'b1, held_data}));
    held = 1'b0;
    if (ks_valid) begin
      if (exp_lat >= 0) begin
        chk("first_valid_cycle", cyc - t_start + 1, exp_lat);
        exp_lat = -1;
      end
      if (ks_ready) begin
        chk("byte_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("ks_data", int'(ks_data), int'(exp_q.pop_front()));
        n_bytes++;
      end else begin
        held = 1'b1;
        held_data = ks_data;
      end
    end
  end

  initial begin
    ks_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ks_ready = 1'b1;
        1:       ks_ready = ~ks_ready;
        default: ks_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    int d0, e0, b0, c, nv;
    logic [8*MKB-1:0] rk;
    int rl, rc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; key = '0; key_len = 8'd0; ks_count = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(ks_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_data", int'(ks_data), 0);

    // Known answer: key "Key", 10 bytes, ready always high.
    rdy_mode = 0;
    d0 = n_done;
    push_kat_key();
    go(K_KEY, 3, 10, 1'b1);
    chk("busy_after_start", int'(busy), 1);
    wait_done(d0);

    // "Wiki" with ready toggling every cycle.
    rdy_mode = 1;
    d0 = n_done;
    model_push(K_WIKI, 4, 6);
    go(K_WIKI, 4, 6, 1'b1);
    wait_done(d0);
    rdy_mode = 0;

    // "Secret" unbounded, abort after the 8th byte.
    d0 = n_done;
    b0 = n_bytes;
`ifdef RC4_DROP_EN
    model_push(K_SECRET, 6, 8);
`else
    foreach (kat_sec[n]) exp_q.push_back(kat_sec[n]);
`endif
    go(K_SECRET, 6, 0, 1'b1);
    c = 0;
    while (n_bytes < b0 + 8 && c < 4000 + 2 * DROP_EFF) begin
      @(negedge clk); c++;
    end
    chk("secret_bytes_seen", n_bytes - b0, 8);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(ks_valid), 0);
    nv = 0;
    repeat (10) begin @(negedge clk); nv += int'(ks_valid); end
    chk("abort_no_valid", nv, 0);
    chk("abort_no_done", n_done - d0, 0);

    // Illegal key lengths and abort+start in IDLE.
    e0 = n_err;
    go(K_KEY, 0, 4, 1'b0);
    chk("err_len0", int'(err), 1);
    chk("err_len0_busy", int'(busy), 0);
    @(posedge clk); #1;
    chk("err_one_cycle", int'(err), 0);
    go(K_KEY, MKB + 1, 4, 1'b0);
    chk("err_len_max1", int'(err), 1);
    chk("err_len_max1_busy", int'(busy), 0);
    @(posedge clk); #1;
    key = K_KEY; key_len = 8'd3; ks_count = 16'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_err", int'(err), 0);
    nv = 0;
    repeat (20) begin @(negedge clk); nv += int'(ks_valid) + int'(busy); end
    chk("idle_quiet", nv, 0);
    chk("err_pulse_count", n_err - e0, 2);

    // Reset mid-KSA, then restart "Key" while a competing start is ignored.
    go(K_KEY, 3, 10, 1'b0);
    repeat (400) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(ks_valid), 0);
    chk("midrst_data", int'(ks_data), 0);
    rdy_mode = 2;
    d0 = n_done;
    push_kat_key();
    go(K_KEY, 3, 10, 1'b1);
    repeat (5) @(posedge clk);
    #1 key = K_WIKI; key_len = 8'd4; ks_count = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_while_busy_err", int'(err), 0);
    wait_done(d0);

    // Random keys, including the 1-byte and maximum-length boundaries.
    for (int it = 0; it < 4; it++) begin
      for (int w = 0; w < MKB / 4; w++) rk[32*w +: 32] = $urandom;
      rl = (it == 0) ? 1 : (it == 1) ? MKB : int'($urandom_range(2, MKB - 1));
      rc = int'($urandom_range(1, 12));
      d0 = n_done;
      model_push(rk, rl, rc);
      go(rk, rl, rc, 1'b1);
      wait_done(d0);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
